stream_min_finder: RTL and testbench
====================================

// Module: stream_min_finder
// PURPOSE
//   Consumes framed streams of unsigned WIDTH-bit values. Returns the frame minimum, the index
//   of its first occurrence and the beat count. Sits directly downstream of the less comparator:
//   it instantiates less (METHOD passed through) to compare each beat against the running
//   minimum. Used for min-search and argmin stages ahead of schedulers and sorters.
// PARAMETERS
//   WIDTH   12  data width in bits, unsigned; passed to less
//   IDX_W   4   index width; up to 2**IDX_W beats per frame are tracked
//   METHOD  0   less implementation select (0..4), passed to less unchanged
// PORTS
//   clk        in   1          rising-edge clock, single clock domain
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   1          input beat valid
//   in_ready   out  1          block can accept a beat
//   in_data    in   WIDTH      input value
//   in_last    in   1          beat is the last of its frame
//   out_valid  out  1          result valid
//   out_ready  in   1          consumer accepts the result
//   out_min    out  WIDTH      minimum value of the frame
//   out_idx    out  IDX_W      index (0-based) of the first beat equal to out_min
//   out_count  out  IDX_W+1    beats in the frame, saturating at all-ones
//   out_ovf    out  1          frame exceeded 2**IDX_W beats
// BEHAVIOUR
//   - Reset: synchronous, active-high.
//     - State goes to IDLE.
//     - out_valid, out_min, out_idx, out_count and out_ovf are all 0.
//     - in_ready is 0 while reset is high.
//     - Any partial frame is discarded; no result is emitted for it.
//   - Beat accepted when in_valid && in_ready. Inputs are ignored when in_valid = 0.
//   - FSM states: IDLE, ACCUM, HOLD. in_ready = 1 in IDLE/ACCUM, 0 in HOLD (combinational from state).
//   - IDLE, beat accepted:
//     - min <= data, idx <= 0, cnt <= 1, ovf <= 0.
//     - in_last = 1 -> HOLD; else -> ACCUM.
//   - ACCUM, beat accepted:
//     - Compare: lt = less(data, min), evaluated combinationally against the registered min.
//     - Track: if cnt < 2**IDX_W and lt, then min <= data and idx <= cnt[IDX_W-1:0].
//       Ties never update, so the earliest index wins.
//     - Overflow: if cnt >= 2**IDX_W, the beat is counted but excluded from the min; ovf <= 1.
//     - Count: cnt increments and saturates at 2**(IDX_W+1)-1.
//     - in_last = 1 -> HOLD.
//   - Entering HOLD: out_min/out_idx/out_count/out_ovf load the final values and out_valid <= 1.
//     The last beat includes its own comparison.
//     - Latency: last beat accepted in cycle N -> out_valid = 1 in cycle N+1.
//   - HOLD: outputs stay stable while out_valid && !out_ready.
//     - On out_valid && out_ready: out_valid <= 0, state -> IDLE; in_ready = 1 the next cycle.
//       Data outputs keep their last values.
//     - Throughput is at most one frame every frame_len+1 cycles.
//   - Single-beat frame: out_min = data, out_idx = 0, out_count = 1.
//   - in_last with in_valid = 0 has no effect.
//   - reset has priority over every other event in the same cycle.
// TESTING
//   - WIDTH=12, IDX_W=4 unless stated; checks run at the first out_valid.
//   - Frame 5,3,7,3(last) -> out_min=3, out_idx=1, out_count=4, out_ovf=0.
//     out_valid rises exactly 1 cycle after the last beat.
//   - Single beat 0xFFF(last) -> out_min=0xFFF, out_idx=0, out_count=1.
//     Then frame 0x000,0x000(last) -> out_min=0, out_idx=0, out_count=2.
//   - Backpressure: out_ready=0 for 5 cycles after the result.
//     -> outputs stable, in_ready=0, no beat accepted while in_valid=1.
//     Raise out_ready -> out_valid drops and in_ready=1 the next cycle.
//   - Overflow: 17 beats of 0x100, beat 16 = 0x001 -> out_min=0x100, out_idx=0, out_count=17, out_ovf=1.
//   - Reset asserted after 2 beats of a frame -> all outputs 0, no out_valid.
//     Then frame 9,8(last) -> out_min=8, out_idx=1, out_count=2.
//   - Random frames, lengths 1..20 with random stalls, METHOD=0,1,2
//     -> every result matches the reference model; no result lost or duplicated.

Source files
------------

// File: rtl/stream_min_finder.sv
// Framed unsigned min/argmin finder: reports the frame minimum, the index of its first
// occurrence, the beat count and an overflow flag, holding the result until accepted.

module less #(
    parameter int WIDTH  = 12,
    parameter int METHOD = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    generate
        if (METHOD == 1) begin : g_sub
            logic [WIDTH:0] diff;
            assign diff = {1'b0, a} - {1'b0, b};
            assign lt   = diff[WIDTH];
        end else if (METHOD == 2) begin : g_msb
            // MSB-first scan: the first differing bit decides the result.
            logic decided;
            always_comb begin
                lt      = 1'b0;
                decided = 1'b0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (!decided && (a[i] != b[i])) begin
                        lt      = b[i];
                        decided = 1'b1;
                    end
                end
            end
        end else if (METHOD == 3) begin : g_ripple
            logic [WIDTH:0] chain;
            assign chain[0] = 1'b0;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
            end
            assign lt = chain[WIDTH];
        end else if (METHOD == 4) begin : g_add
            // a + ~b + 1 carries out exactly when a >= b.
            logic [WIDTH:0] sum;
            assign sum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
            assign lt  = ~sum[WIDTH];
        end else begin : g_direct
            assign lt = (a < b);
        end
    endgenerate

endmodule

module stream_min_finder #(
    parameter int WIDTH  = 12,
    parameter int IDX_W  = 4,
    parameter int METHOD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] min_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W:0]   cnt_r;
    logic             ovf_r;

    logic             lt;
    logic             accept;
    logic             full;
    logic [WIDTH-1:0] nxt_min;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W:0]   nxt_cnt;
    logic             nxt_ovf;

    assign in_ready = !reset && (state != HOLD);
    assign accept   = in_valid && in_ready;
    // Top count bit set means 2**IDX_W beats are already in: later beats are only counted.
    assign full     = cnt_r[IDX_W];

    less #(
        .WIDTH (WIDTH),
        .METHOD(METHOD)
    ) u_less (
        .a (in_data),
        .b (min_r),
        .lt(lt)
    );

    always_comb begin
        nxt_min = min_r;
        nxt_idx = idx_r;
        nxt_cnt = cnt_r;
        nxt_ovf = ovf_r;
        if (state == IDLE) begin
            nxt_min = in_data;
            nxt_idx = '0;
            nxt_cnt = (IDX_W + 1)'(1);
            nxt_ovf = 1'b0;
        end else begin
            nxt_ovf = ovf_r | full;
            nxt_cnt = (&cnt_r) ? cnt_r : cnt_r + (IDX_W + 1)'(1);
            // Strict less-than: ties keep the earlier index.
            if (!full && lt) begin
                nxt_min = in_data;
                nxt_idx = cnt_r[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            min_r     <= '0;
            idx_r     <= '0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        min_r <= nxt_min;
                        idx_r <= nxt_idx;
                        cnt_r <= nxt_cnt;
                        ovf_r <= nxt_ovf;
                        if (in_last) begin
                            out_min   <= nxt_min;
                            out_idx   <= nxt_idx;
                            out_count <= nxt_cnt;
                            out_ovf   <= nxt_ovf;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_min_finder.sv
// Scoreboard bench for stream_min_finder: METHOD 0/1/2 instances share one stimulus stream,
// expected results are queued at issue time and popped by a monitor on each output handshake.

module tb_stream_min_finder;

    typedef struct {
        logic [11:0] mn;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready  [3];
    logic        out_valid [3];
    logic [11:0] out_min   [3];
    logic [3:0]  out_idx   [3];
    logic [4:0]  out_count [3];
    logic        out_ovf   [3];

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   randReady = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stream_min_finder #(
            .WIDTH (12),
            .IDX_W (4),
            .METHOD(g)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .in_last  (in_last),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_min  (out_min[g]),
            .out_idx  (out_idx[g]),
            .out_count(out_count[g]),
            .out_ovf  (out_ovf[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [11:0] mn, input logic [3:0] idx, input logic [4:0] cnt,
                           input logic ovf);
        exp_t e;
        e.mn = mn; e.idx = idx; e.cnt = cnt; e.ovf = ovf;
        sb.push_back(e);
    endtask

    // Called just after a posedge; returns just after the posedge that accepted the beat.
    task automatic applyStimulus(input logic [11:0] d, input logic last);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready[0] && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 200) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("drain_timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("%s_valid[%0d]", tag, g), out_valid[g], 32'd0);
            checkOutput($sformatf("%s_min[%0d]", tag, g), out_min[g], 32'd0);
            checkOutput($sformatf("%s_idx[%0d]", tag, g), out_idx[g], 32'd0);
            checkOutput($sformatf("%s_count[%0d]", tag, g), out_count[g], 32'd0);
            checkOutput($sformatf("%s_ovf[%0d]", tag, g), out_ovf[g], 32'd0);
        end
    endtask

    // Monitor: one pop per output handshake, compared across all three instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid[0] && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    for (int g = 0; g < 3; g++) begin
                        checkOutput($sformatf("valid[%0d]", g), out_valid[g], 32'd1);
                        checkOutput($sformatf("min[%0d]", g), out_min[g], e.mn);
                        checkOutput($sformatf("idx[%0d]", g), out_idx[g], e.idx);
                        checkOutput($sformatf("count[%0d]", g), out_count[g], e.cnt);
                        checkOutput($sformatf("ovf[%0d]", g), out_ovf[g], e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [11:0] frame [20];
        logic [11:0] mn;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        logic        ovf;
        int          len;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        checkOutput("reset_in_ready", in_ready[0], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        pushExp(12'd3, 4'd1, 5'd4, 1'b0);
        applyStimulus(12'd5, 1'b0);
        applyStimulus(12'd3, 1'b0);
        applyStimulus(12'd7, 1'b0);
        applyStimulus(12'd3, 1'b1);
        checkOutput("latency_valid", out_valid[0], 32'd1);

        pushExp(12'hFFF, 4'd0, 5'd1, 1'b0);
        applyStimulus(12'hFFF, 1'b1);
        pushExp(12'h000, 4'd0, 5'd2, 1'b0);
        applyStimulus(12'h000, 1'b0);
        applyStimulus(12'h000, 1'b1);
        drain();

        out_ready = 1'b0;
        pushExp(12'h0AB, 4'd0, 5'd2, 1'b0);
        applyStimulus(12'h0AB, 1'b0);
        applyStimulus(12'h0CD, 1'b1);
        in_valid = 1'b1;
        in_data  = 12'h001;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_valid", out_valid[0], 32'd1);
            checkOutput("bp_min", out_min[0], 32'h0AB);
            checkOutput("bp_count", out_count[0], 32'd2);
            checkOutput("bp_in_ready", in_ready[0], 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", out_valid[0], 32'd0);
        checkOutput("release_in_ready", in_ready[0], 32'd1);
        checkOutput("release_min_kept", out_min[0], 32'h0AB);

        pushExp(12'h100, 4'd0, 5'd17, 1'b1);
        for (int i = 0; i < 17; i++)
            applyStimulus((i == 16) ? 12'h001 : 12'h100, (i == 16));
        drain();

        applyStimulus(12'h050, 1'b0);
        applyStimulus(12'h020, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_ready", in_ready[0], 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("midreset");
        repeat (3) begin
            @(negedge clk);
            checkOutput("midreset_no_valid", out_valid[0], 32'd0);
        end
        @(posedge clk);
        #1;
        pushExp(12'd8, 4'd1, 5'd2, 1'b0);
        applyStimulus(12'd9, 1'b0);
        applyStimulus(12'd8, 1'b1);
        drain();

        randReady = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                frame[i] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 15))
                                                       : 12'($urandom_range(0, 4095));
            mn = frame[0]; idx = 4'd0; cnt = 5'd1; ovf = 1'b0;
            for (int i = 1; i < len; i++) begin
                if (i >= 16) ovf = 1'b1;
                else if (frame[i] < mn) begin
                    mn  = frame[i];
                    idx = 4'(i);
                end
                cnt = (cnt == 5'd31) ? cnt : cnt + 5'd1;
            end
            pushExp(mn, idx, cnt, ovf);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(frame[i], (i == len - 1));
            end
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (10) @(posedge clk);
        checkOutput("leftover_results", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
